key_debouncer: RTL and testbench

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/key_debouncer_pkg.sv | 15 +
 rtl/key_debounce_chan.sv | 94 +++++++++
 rtl/key_debouncer.sv | 30 +++
 tb/tb_key_debouncer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// Shared types for the key debouncer: per-channel debounce FSM states.
`ifndef KEYS_W
`define KEYS_W 4
`endif

package key_debouncer_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } deb_state_e;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered level output and one-cycle press/release pulses.
module key_debounce_chan
   import key_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic key_o,
   output logic press_o,
   output logic release_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1, s2;
   deb_state_e       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             press_nx, release_nx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= RELEASED;
         cnt       <= '0;
         key_o     <= 1'b0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
      end else begin
         s1        <= key_i;
         s2        <= s1;
         state     <= state_nx;
         cnt       <= cnt_nx;
         // decoded from the next state so the level lines up with the pulses
         key_o     <= (state_nx == PRESSED) || (state_nx == RELEASE_PEND);
         press_o   <= press_nx;
         release_o <= release_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
         RELEASED: begin
            if (s2) begin
               state_nx = PRESS_PEND;
               cnt_nx   = '0;
            end
         end
         PRESS_PEND: begin
            if (!s2) begin
               state_nx = RELEASED;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
               press_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!s2) begin
               state_nx = RELEASE_PEND;
               cnt_nx   = '0;
            end
         end
         RELEASE_PEND: begin
            if (s2) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx   = RELEASED;
               cnt_nx     = '0;
               release_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = RELEASED;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_debouncer.sv
// Debounces KEYS_W independent active-high keys between the board input
// inversion and game_top; one key_debounce_chan per key.
module key_debouncer
   import key_debouncer_pkg::*;
#(
   parameter int unsigned KEYS_W          = `KEYS_W,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [KEYS_W-1:0] keys_i,
   output logic [KEYS_W-1:0] keys_o,
   output logic [KEYS_W-1:0] press_o,
   output logic [KEYS_W-1:0] release_o
);

   for (genvar i = 0; i < KEYS_W; i++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .key_i    (keys_i[i]),
         .key_o    (keys_o[i]),
         .press_o  (press_o[i]),
         .release_o(release_o[i])
      );
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: run-length reference model feeding a scoreboard,
// plus directed latency/glitch/reset sequences and a random bounce run.
module tb_key_debouncer;

   localparam int KW = 4;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [KW-1:0] keys = '0;
   logic [KW-1:0] keys_o, press_o, release_o;

   key_debouncer #(.KEYS_W(KW), .DEBOUNCE_CYCLES(DC)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .keys_i   (keys),
      .keys_o   (keys_o),
      .press_o  (press_o),
      .release_o(release_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: debounced level flips once the synchronized input has
   // disagreed with it on DC+1 consecutive sampling edges.
   typedef struct packed {
      logic [KW-1:0] k;
      logic [KW-1:0] p;
      logic [KW-1:0] r;
   } exp_t;

   exp_t          sb_q[$];
   logic [KW-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
   int            m_run[KW] = '{default: 0};
   int            m_press_cnt = 0, m_rel_cnt = 0;
   int            d_press_cnt = 0, d_rel_cnt = 0;

   always @(posedge clk) begin
      exp_t          e;
      logic [KW-1:0] deb_nx;
      int            run_nx[KW];
      e      = '0;
      deb_nx = m_deb;
      if (rst) begin
         m_s1  <= '0;
         m_s2  <= '0;
         m_deb <= '0;
         for (int i = 0; i < KW; i++) m_run[i] <= 0;
      end else begin
         for (int i = 0; i < KW; i++) begin
            if (m_s2[i] == m_deb[i]) run_nx[i] = 0;
            else if (m_run[i] == DC) begin
               deb_nx[i] = ~m_deb[i];
               run_nx[i] = 0;
               if (m_s2[i]) e.p[i] = 1'b1;
               else         e.r[i] = 1'b1;
            end else run_nx[i] = m_run[i] + 1;
            m_run[i] <= run_nx[i];
         end
         m_s1  <= keys;
         m_s2  <= m_s1;
         m_deb <= deb_nx;
         e.k   = deb_nx;
         m_press_cnt <= m_press_cnt + $countones(e.p);
         m_rel_cnt   <= m_rel_cnt + $countones(e.r);
      end
      sb_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("scoreboard", 32'({keys_o, press_o, release_o}), 32'(e));
         chk("coincident", 32'(press_o & release_o), 32'(0));
         d_press_cnt <= d_press_cnt + $countones(press_o);
         d_rel_cnt   <= d_rel_cnt + $countones(release_o);
      end
   end

   // advance one cycle; inputs change and directed checks happen just after negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // after driving a change, edge k is the k-th posedge; pulse expected only at at_edge
   task automatic expect_pulse(input string tag, input bit rel, input logic [KW-1:0] exp_v,
                               input int at_edge, input int n_edges);
      for (int k = 0; k < n_edges; k++) begin
         step();
         chk(tag, 32'(rel ? release_o : press_o), (k == at_edge) ? 32'(exp_v) : 32'(0));
      end
   endtask

   logic [9:0] bounce_pat;
   logic [KW-1:0] tgt;
   int bounce_left[KW];

   initial begin
      idle(3);
      chk("reset_keys", 32'(keys_o), 32'(0));
      chk("reset_pulses", 32'({press_o, release_o}), 32'(0));
      rst = 1'b0;
      idle(3);

      // clean press on bit0, held 20 cycles, then released
      keys = 4'b0001;
      expect_pulse("press_bit0", 1'b0, 4'b0001, 6, 20);
      chk("level_bit0", 32'(keys_o), 32'(4'b0001));
      keys = 4'b0000;
      expect_pulse("release_bit0", 1'b1, 4'b0001, 6, 10);
      chk("level_bit0_off", 32'(keys_o), 32'(0));

      // 3-cycle glitch on bit1 is rejected
      keys = 4'b0010;
      for (int k = 0; k < 15; k++) begin
         step();
         chk("glitch_bit1", 32'({keys_o, press_o, release_o}), 32'(0));
         if (k == 2) keys = 4'b0000;
      end

      // bounce sequence on bit2 (index 0 first), then hold
      bounce_pat = 10'b1111101101;
      keys[2] = bounce_pat[0];
      for (int k = 0; k < 20; k++) begin
         step();
         chk("bounce_bit2", 32'(press_o), (k == 11) ? 32'(4'b0100) : 32'(0));
         keys[2] = (k + 1 < 10) ? bounce_pat[k+1] : 1'b1;
      end
      keys = 4'b0000;
      idle(12);

      // simultaneous press and release on bits 0 and 3
      keys = 4'b1001;
      expect_pulse("press_multi", 1'b0, 4'b1001, 6, 20);
      keys = 4'b0000;
      expect_pulse("release_multi", 1'b1, 4'b1001, 6, 10);

      // reset two cycles into PRESS_PEND with key held
      keys = 4'b0001;
      expect_pulse("pre_reset", 1'b0, 4'b0000, -1, 5);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("in_reset", 32'({keys_o, press_o, release_o}), 32'(0));
      end
      rst = 1'b0;
      expect_pulse("post_reset_press", 1'b0, 4'b0001, 6, 12);
      keys = 4'b0000;
      idle(12);

      // random bounce stress against the model
      tgt = '0;
      bounce_left = '{default: 0};
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < KW; i++) begin
            if (bounce_left[i] == 0 && $urandom_range(59, 0) == 0) begin
               tgt[i] = ~tgt[i];
               bounce_left[i] = $urandom_range(8, 1);
            end
            if (bounce_left[i] > 0) begin
               keys[i] = 1'($urandom_range(1, 0));
               bounce_left[i]--;
            end else keys[i] = tgt[i];
         end
         step();
      end
      keys = '0;
      idle(20);
      chk("press_count", 32'(d_press_cnt), 32'(m_press_cnt));
      chk("release_count", 32'(d_rel_cnt), 32'(m_rel_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
